// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - phase tick prescaler and countdown feeding the traffic-light controller
// Optional macro PED_SHORTEN_EN adds pedReq, which cuts a running green short to count 3.
module traffic_phase_timer #(
    parameter int TICK_DIV   = 50000000,
    parameter int GREEN_LEN  = 6,
    parameter int YELLOW_LEN = 3,
    parameter int RED_LEN    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lightIn,
`ifdef PED_SHORTEN_EN
    input  logic       pedReq,
`endif
    output logic [2:0] count,
    output logic       tick,
    output logic       phaseErr
);

    localparam int              PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]      L_GREEN  = 3'd1;
    localparam logic [2:0]      L_YELLOW = 3'd2;
    localparam logic [2:0]      L_RED    = 3'd4;

    logic [PW-1:0] prescaler;
    logic [2:0]    light_prev;
    logic          legal;
    logic          change;
    logic [2:0]    reload_val;
    logic [2:0]    count_next;
    logic          err_next;
`ifdef PED_SHORTEN_EN
    logic          ped_latch;
    logic          ped_latch_next;
    logic          ped_pend;
`endif

    // Free-running divider; phase reloads deliberately leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + 1'b1;
            tick      <= (prescaler == PRE_MAX);
        end
    end

    always_comb begin
        legal      = (lightIn == L_GREEN) || (lightIn == L_YELLOW) || (lightIn == L_RED);
        change     = (lightIn != light_prev);
        reload_val = 3'(RED_LEN);
        if (lightIn == L_GREEN)
            reload_val = 3'(GREEN_LEN);
        else if (lightIn == L_YELLOW)
            reload_val = 3'(YELLOW_LEN);
    end

    always_comb begin
        count_next = count;
        err_next   = phaseErr;
`ifdef PED_SHORTEN_EN
        ped_pend       = ped_latch || (pedReq && (lightIn == L_GREEN));
        ped_latch_next = ped_latch;
        if (legal && change)
            ped_latch_next = 1'b0;
        else if (pedReq && (lightIn == L_GREEN))
            ped_latch_next = 1'b1;
`endif
        if (!legal) begin
            count_next = 3'd0;
            err_next   = 1'b1;
        end else if (change) begin
            count_next = reload_val;
`ifdef PED_SHORTEN_EN
        end else if (ped_pend && (count > 3'd3)) begin
            count_next = 3'd3;
`endif
        end else if (tick && (count > 3'd1)) begin
            count_next = count - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= 3'd0;
            light_prev <= 3'b000;
            phaseErr   <= 1'b0;
        end else begin
            count      <= count_next;
            light_prev <= lightIn;
            phaseErr   <= err_next;
        end
    end

`ifdef PED_SHORTEN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ped_latch <= 1'b0;
        else
            ped_latch <= ped_latch_next;
    end
`endif

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed and random checks of traffic_phase_timer against a cycle-count model
module tb_traffic_phase_timer;

    localparam int TD = 4;
    localparam int GL = 6;
    localparam int YL = 3;
    localparam int RL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] lightIn = 3'd0;
    logic       pedReq = 1'b0;
    logic [2:0] count;
    logic       tick;
    logic       phaseErr;

    int total = 0;
    int bad   = 0;

    // Reference state: edges since reset release drive the tick arithmetically.
    int         m_edges;
    int         m_count;
    logic       m_tick;
    logic       m_err;
    logic [2:0] m_prev;
    logic       m_latch;

    traffic_phase_timer #(
        .TICK_DIV(TD), .GREEN_LEN(GL), .YELLOW_LEN(YL), .RED_LEN(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lightIn(lightIn),
`ifdef PED_SHORTEN_EN
        .pedReq(pedReq),
`endif
        .count(count),
        .tick(tick),
        .phaseErr(phaseErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int reload_of(input logic [2:0] l);
        if (l == 3'd1) return GL;
        if (l == 3'd2) return YL;
        return RL;
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_count = 0;
        m_tick  = 1'b0;
        m_err   = 1'b0;
        m_prev  = 3'b000;
        m_latch = 1'b0;
    endtask

    task automatic model_step();
        logic tick_before;
        logic legal;
        logic pend;
        tick_before = m_tick;
        legal = (lightIn == 3'd1) || (lightIn == 3'd2) || (lightIn == 3'd4);
`ifdef PED_SHORTEN_EN
        pend = m_latch || (pedReq && lightIn == 3'd1);
`else
        pend = 1'b0;
`endif
        if (!legal) begin
            m_count = 0;
            m_err   = 1'b1;
        end else if (lightIn != m_prev) begin
            m_count = reload_of(lightIn);
            m_latch = 1'b0;
        end else begin
`ifdef PED_SHORTEN_EN
            if (pedReq && lightIn == 3'd1) m_latch = 1'b1;
`endif
            if (pend && m_count > 3) m_count = 3;
            else if (tick_before && m_count > 1) m_count = m_count - 1;
        end
        m_prev  = lightIn;
        m_edges = m_edges + 1;
        m_tick  = (m_edges % TD == 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("count", int'(count), m_count);
        check("tick", int'(tick), int'(m_tick));
        check("phaseErr", int'(phaseErr), int'(m_err));
    endtask

    // Called between edges; reset takes effect without any clock edge.
    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_count", int'(count), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_err", int'(phaseErr), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_count", int'(count), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_err", int'(phaseErr), 0);
        @(negedge clk);
        rst = 1'b1;
        lightIn = 3'd4;

        // Red from reset: immediate reload, then countdown to a floor of 1.
        cycle();
        check("red_first", int'(count), 5);
        for (int i = 0; i < 24; i++) cycle();
        check("red_floor", int'(count), 1);

        // Green reload, then let it run to its floor.
        lightIn = 3'd1;
        cycle();
        check("green_reload", int'(count), 6);
        for (int i = 0; i < 10; i++) cycle();

        // Change coinciding with a tick: reload value, not reload-1.
        for (int i = 0; i < 2 * TD && !m_tick; i++) cycle();
        check("wait_tick", int'(m_tick), 1);
        lightIn = 3'd2;
        cycle();
        check("tick_reload", int'(count), 3);

        // Illegal value for one cycle, then a legal one.
        lightIn = 3'd3;
        cycle();
        check("illegal_count", int'(count), 0);
        check("illegal_err", int'(phaseErr), 1);
        lightIn = 3'd2;
        cycle();
        check("recover_count", int'(count), 3);
        check("recover_err", int'(phaseErr), 1);

        // Reset mid-yellow at count 2.
        for (int i = 0; i < 3 * TD && count != 3'd2; i++) cycle();
        check("wait_yellow2", int'(count), 2);
        async_reset();
        lightIn = 3'd2;
        cycle();
        check("post_rst_yellow", int'(count), 3);

`ifdef PED_SHORTEN_EN
        lightIn = 3'd1;
        cycle();
        check("ped_green", int'(count), 6);
        pedReq = 1'b1;
        cycle();
        check("ped_short", int'(count), 3);
        pedReq = 1'b0;
        for (int i = 0; i < 3 * TD && count != 3'd2; i++) cycle();
        check("ped_wait2", int'(count), 2);
        pedReq = 1'b1;
        cycle();
        pedReq = 1'b0;
`endif

        // Random phases with occasional illegal values and resets.
        for (int n = 0; n < 250; n++) begin
            int r;
            int hold;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                async_reset();
                continue;
            end else if (r == 1) begin
                case ($urandom_range(0, 4))
                    0: lightIn = 3'd0;
                    1: lightIn = 3'd3;
                    2: lightIn = 3'd5;
                    3: lightIn = 3'd6;
                    default: lightIn = 3'd7;
                endcase
                hold = int'($urandom_range(1, 2));
            end else begin
                case ($urandom_range(0, 2))
                    0: lightIn = 3'd1;
                    1: lightIn = 3'd2;
                    default: lightIn = 3'd4;
                endcase
                hold = int'($urandom_range(1, 14));
            end
            for (int i = 0; i < hold; i++) begin
                pedReq = ($urandom_range(0, 7) == 0);
                cycle();
            end
            pedReq = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
